// File: rtl/mac_tx_axis_fifo_if.sv
// AXI-Stream bundle used on both sides of the MAC TX packet FIFO.
// tuser carries the "frame bad" flag on the source side and is tied off on the MAC side.
interface mac_tx_axis_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_BYTES = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_BYTES-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/mac_tx_axis_fifo.sv
// Store-and-forward TX packet FIFO in front of the MAC: a frame becomes visible only once its
// last beat is stored, so the MAC never underruns. Overflowing or source-flagged frames are dropped.
module mac_tx_axis_fifo #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned AXIS_DATA_BYTES = 4,
  parameter int unsigned FIFO_DEPTH      = 512
) (
  input  logic                          mac_clk,
  input  logic                          mac_rst,
  mac_tx_axis_fifo_if.slave             s_axis,
  mac_tx_axis_fifo_if.master            m_axis,
  output logic                          drop_frame,
  output logic [31:0]                   stat_drop_frames,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW = PW - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  typedef struct packed {
    logic                       last;
    logic [AXIS_DATA_BYTES-1:0] keep;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];

  logic [1:0]      state_q,     state_d;
  logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [PW-1:0]   level_q,     level_d;
  entry_t          out_q,       out_d;
  logic            out_valid_q, out_valid_d;
  logic            drop_q,      drop_d;
  logic [31:0]     stat_q,      stat_d;
  logic            ready_q;
  logic            mem_we;

  logic            beat_in;
  logic            full;
  logic            out_fire;
  logic            load;
  entry_t          in_entry;
  entry_t          rd_entry;

  assign beat_in  = s_axis.tvalid && ready_q;
  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
  assign out_fire = out_valid_q && m_axis.tready;
  // Only committed entries may be pulled into the output register.
  assign load     = (rd_ptr_q != wr_commit_q) && (!out_valid_q || out_fire);
  assign in_entry = '{last: s_axis.tlast, keep: s_axis.tkeep, data: s_axis.tdata};
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  // Next-state: write-side frame FSM, drop accounting and read-side output register.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    drop_d      = 1'b0;
    stat_d      = stat_q;
    mem_we      = 1'b0;

    if (beat_in) begin
      if (state_q == ST_DROP) begin
        if (s_axis.tlast) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
          stat_d  = stat_q + 32'd1;
        end
      end else if (full) begin
        // Rewind the partial frame; a full-on-tlast beat finishes the drop right away.
        wr_ptr_d = wr_commit_q;
        if (s_axis.tlast) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
          stat_d  = stat_q + 32'd1;
        end else begin
          state_d = ST_DROP;
        end
      end else if (s_axis.tlast && s_axis.tuser) begin
        wr_ptr_d = wr_commit_q;
        state_d  = ST_IDLE;
        drop_d   = 1'b1;
        stat_d   = stat_q + 32'd1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (s_axis.tlast) begin
          wr_commit_d = wr_ptr_q + PW'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_ACTIVE;
        end
      end
    end

    if (load) begin
      out_d       = rd_entry;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    level_d = wr_ptr_d - rd_ptr_d;
  end

  // State and pointer registers.
  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      stat_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      stat_q      <= stat_d;
      ready_q     <= 1'b1;
    end
  end

  // Beat storage; contents are don't-care after reset since all pointers clear.
  always_ff @(posedge mac_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= in_entry;
    end
  end

  assign s_axis.tready    = ready_q;
  assign m_axis.tdata     = out_q.data;
  assign m_axis.tkeep     = out_q.keep;
  assign m_axis.tlast     = out_q.last;
  assign m_axis.tvalid    = out_valid_q;
  assign m_axis.tuser     = 1'b0;
  assign drop_frame       = drop_q;
  assign stat_drop_frames = stat_q;
  assign stat_fifo_level  = level_q;

endmodule
